poly_pingpong_ram: RTL and testbench

//  Double-buffered (ping-pong) polynomial store for the preprocess path. Two buffers of NUM_BASE_BANK banks x 2^ADDR_WIDTH

---
 rtl/poly_pingpong_ram.sv | 132 +++++++++++++
 tb/tb_poly_pingpong_ram.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_pingpong_ram.sv
// Double-buffered polynomial store: a producer fills one buffer while a consumer reads the other.
// Buffer ownership changes hands on wr_done / rd_done pulses.
module poly_pingpong_ram #(
    parameter int unsigned COE_WIDTH         = 39,
    parameter int          Q_TYPE            = 0,
    parameter int unsigned ADDR_WIDTH        = 9,
    parameter int unsigned NUM_BASE_BANK     = 8,
    parameter int unsigned COMMON_BRAM_DELAY = 2
) (
    input  logic                                i_clk,
    input  logic                                i_rst,
    input  logic [NUM_BASE_BANK-1:0]            i_wr_en,
    input  logic [ADDR_WIDTH*NUM_BASE_BANK-1:0] i_wr_addr,
    input  logic [COE_WIDTH*NUM_BASE_BANK-1:0]  i_wr_data,
    input  logic                                i_wr_done,
    output logic                                o_wr_ready,
    input  logic                                i_rd_en,
    input  logic [ADDR_WIDTH*NUM_BASE_BANK-1:0] i_rd_addr,
    input  logic                                i_rd_done,
    output logic                                o_rd_ready,
    output logic                                o_rd_valid,
    output logic [COE_WIDTH*NUM_BASE_BANK-1:0]  o_rd_data,
    output logic [1:0]                          o_buf_cnt,
    output logic [1:0]                          o_err
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned DW    = COE_WIDTH * NUM_BASE_BANK;

    if (COMMON_BRAM_DELAY < 1 || Q_TYPE < 0) begin : g_bad_param
        $error("poly_pingpong_ram: COMMON_BRAM_DELAY must be >= 1 and Q_TYPE >= 0");
    end

    logic [1:0]                   r_full;
    logic                         r_wr_sel;
    logic                         r_rd_sel;
    logic [1:0]                   r_buf_cnt;
    logic [1:0]                   r_err;
    logic [COMMON_BRAM_DELAY-1:0] r_vld;
    logic                         r_rd_buf;

    logic        w_wr_ready;
    logic        w_rd_ready;
    logic        w_wr_commit;
    logic        w_rd_release;
    logic        w_rd_fire;
    logic [1:0]  w_full_nxt;
    logic [DW-1:0] w_ram_out;
    logic [DW-1:0] w_rd_out;

    assign w_wr_ready   = ~r_full[r_wr_sel];
    assign w_rd_ready   = r_full[r_rd_sel];
    assign w_wr_commit  = i_wr_done & w_wr_ready;
    assign w_rd_release = i_rd_done & w_rd_ready;
    assign w_rd_fire    = i_rd_en & w_rd_ready;

    // wr_sel and rd_sel never name the same buffer when both pulses are honoured
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_commit) w_full_nxt[r_wr_sel] = 1'b1;
        if (w_rd_release) w_full_nxt[r_rd_sel] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_full    <= 2'b00;
            r_wr_sel  <= 1'b0;
            r_rd_sel  <= 1'b0;
            r_buf_cnt <= 2'd0;
            r_err     <= 2'b00;
            r_vld     <= '0;
        end else begin
            r_full    <= w_full_nxt;
            r_wr_sel  <= r_wr_sel ^ w_wr_commit;
            r_rd_sel  <= r_rd_sel ^ w_rd_release;
            r_buf_cnt <= {1'b0, w_full_nxt[0]} + {1'b0, w_full_nxt[1]};
            if ((|i_wr_en || i_wr_done) && !w_wr_ready) r_err[0] <= 1'b1;
            if ((i_rd_en || i_rd_done) && !w_rd_ready) r_err[1] <= 1'b1;
            r_vld[0] <= w_rd_fire;
            for (int s = 1; s < COMMON_BRAM_DELAY; s++) r_vld[s] <= r_vld[s-1];
        end
    end

    // Remember which buffer was read so the output mux ignores later rd_sel toggles
    always_ff @(posedge i_clk) begin
        if (w_rd_fire) r_rd_buf <= r_rd_sel;
    end

    for (genvar b = 0; b < NUM_BASE_BANK; b++) begin : g_bank
        logic [COE_WIDTH-1:0]  r_mem0 [DEPTH];
        logic [COE_WIDTH-1:0]  r_mem1 [DEPTH];
        logic [COE_WIDTH-1:0]  r_q0;
        logic [COE_WIDTH-1:0]  r_q1;
        logic [ADDR_WIDTH-1:0] w_wa;
        logic [ADDR_WIDTH-1:0] w_ra;
        logic [COE_WIDTH-1:0]  w_wd;

        assign w_wa = i_wr_addr[(b+1)*ADDR_WIDTH-1 -: ADDR_WIDTH];
        assign w_ra = i_rd_addr[(b+1)*ADDR_WIDTH-1 -: ADDR_WIDTH];
        assign w_wd = i_wr_data[(b+1)*COE_WIDTH-1 -: COE_WIDTH];

        always_ff @(posedge i_clk) begin
            if (i_wr_en[b] && w_wr_ready) begin
                if (r_wr_sel) r_mem1[w_wa] <= w_wd;
                else          r_mem0[w_wa] <= w_wd;
            end
            if (w_rd_fire) begin
                r_q0 <= r_mem0[w_ra];
                r_q1 <= r_mem1[w_ra];
            end
        end

        assign w_ram_out[(b+1)*COE_WIDTH-1 -: COE_WIDTH] = r_rd_buf ? r_q1 : r_q0;
    end

    if (COMMON_BRAM_DELAY == 1) begin : g_no_dly
        assign w_rd_out = w_ram_out;
    end else begin : g_dly
        logic [DW-1:0] r_dreg [COMMON_BRAM_DELAY-1];
        always_ff @(posedge i_clk) begin
            r_dreg[0] <= w_ram_out;
            for (int s = 1; s < COMMON_BRAM_DELAY - 1; s++) r_dreg[s] <= r_dreg[s-1];
        end
        assign w_rd_out = r_dreg[COMMON_BRAM_DELAY-2];
    end

    assign o_wr_ready = w_wr_ready;
    assign o_rd_ready = w_rd_ready;
    assign o_rd_valid = r_vld[COMMON_BRAM_DELAY-1];
    assign o_rd_data  = o_rd_valid ? w_rd_out : '0;
    assign o_buf_cnt  = r_buf_cnt;
    assign o_err      = r_err;
endmodule

// File: tb/tb_poly_pingpong_ram.sv
// Directed plus random stimulus for poly_pingpong_ram, checked each cycle against an array/queue
// model of the two buffers built from the ownership rules.
module tb_poly_pingpong_ram;
    localparam int D     = 2;
    localparam int NB    = 8;
    localparam int AW    = 9;
    localparam int W     = 39;
    localparam int DW    = W * NB;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] wr_en;
    logic [AW*NB-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_done;
    logic          wr_ready;
    logic          rd_en;
    logic [AW*NB-1:0] rd_addr;
    logic          rd_done;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [1:0]    buf_cnt;
    logic [1:0]    err;

    poly_pingpong_ram #(
        .COE_WIDTH(W), .Q_TYPE(0), .ADDR_WIDTH(AW), .NUM_BASE_BANK(NB), .COMMON_BRAM_DELAY(D)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_done(wr_done),
        .o_wr_ready(wr_ready),
        .i_rd_en(rd_en), .i_rd_addr(rd_addr), .i_rd_done(rd_done),
        .o_rd_ready(rd_ready), .o_rd_valid(rd_valid), .o_rd_data(rd_data),
        .o_buf_cnt(buf_cnt), .o_err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_t;

    logic [W-1:0] m_mem [2][NB][DEPTH];
    bit   [1:0]   m_full;
    bit           m_wsel;
    bit           m_rsel;
    bit   [1:0]   m_err;
    rd_t          m_q[$];
    int           cyc = 0;
    int           n_vec = 0;
    int           n_mis = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr_en = '0; wr_done = 0; rd_en = 0; rd_done = 0; rst = 0;
    endtask

    function automatic logic [W-1:0] rnd_coe();
        return W'({$urandom, $urandom});
    endfunction

    task automatic rand_wr(input logic [NB-1:0] en);
        wr_en = en;
        for (int i = 0; i < NB; i++) begin
            wr_addr[i*AW +: AW] = AW'($urandom);
            wr_data[i*W +: W]   = rnd_coe();
        end
    endtask

    task automatic rand_rd();
        rd_en = 1;
        for (int i = 0; i < NB; i++) rd_addr[i*AW +: AW] = AW'($urandom);
    endtask

    // Apply model rules for the current inputs, clock once, then compare every output.
    task automatic step();
        bit wr_ok, rd_ok, exp_valid;
        rd_t r;
        logic [DW-1:0] exp_data;
        if (rst) begin
            m_full = 2'b00; m_wsel = 0; m_rsel = 0; m_err = 2'b00;
            m_q.delete();
        end else begin
            wr_ok = !m_full[m_wsel];
            rd_ok = m_full[m_rsel];
            if (rd_en) begin
                if (rd_ok) begin
                    for (int i = 0; i < NB; i++)
                        r.data[i*W +: W] = m_mem[m_rsel][i][rd_addr[i*AW +: AW]];
                    r.due = cyc + D;
                    m_q.push_back(r);
                end else m_err[1] = 1;
            end
            if (|wr_en) begin
                if (wr_ok) begin
                    for (int i = 0; i < NB; i++)
                        if (wr_en[i]) m_mem[m_wsel][i][wr_addr[i*AW +: AW]] = wr_data[i*W +: W];
                end else m_err[0] = 1;
            end
            if (wr_done) begin
                if (wr_ok) begin m_full[m_wsel] = 1; m_wsel = !m_wsel; end
                else m_err[0] = 1;
            end
            if (rd_done) begin
                if (rd_ok) begin m_full[m_rsel] = 0; m_rsel = !m_rsel; end
                else m_err[1] = 1;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        exp_valid = (m_q.size() > 0) && (m_q[0].due == cyc);
        exp_data  = '0;
        if (exp_valid) begin
            exp_data = m_q[0].data;
            void'(m_q.pop_front());
        end
        chk("wr_ready", DW'(wr_ready), DW'(!m_full[m_wsel]));
        chk("rd_ready", DW'(rd_ready), DW'(m_full[m_rsel]));
        chk("buf_cnt", DW'(buf_cnt), DW'(m_full[0] + m_full[1]));
        chk("err", DW'(err), DW'(m_err));
        chk("rd_valid", DW'(rd_valid), DW'(exp_valid));
        chk("rd_data", rd_data, exp_data);
    endtask

    task automatic drain(input int n);
        idle();
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        idle();
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        rst = 1;
        step();
        chk("reset_wr_ready", DW'(wr_ready), DW'(1));
        chk("reset_rd_ready", DW'(rd_ready), DW'(0));
        chk("reset_buf_cnt", DW'(buf_cnt), DW'(0));
        chk("reset_err", DW'(err), DW'(0));
        idle();

        // 1: lane i, addr a holds i*512+a; read back in order
        for (int a = 0; a < DEPTH; a++) begin
            wr_en = '1;
            for (int i = 0; i < NB; i++) begin
                wr_addr[i*AW +: AW] = AW'(a);
                wr_data[i*W +: W]   = W'(i * 512 + a);
            end
            step();
        end
        idle(); wr_done = 1; step(); idle();
        chk("t1_buf_cnt_full", DW'(buf_cnt), DW'(1));
        for (int a = 0; a < DEPTH; a++) begin
            rd_en = 1;
            for (int i = 0; i < NB; i++) rd_addr[i*AW +: AW] = AW'(a);
            step();
            if (a == 1) chk("t1_first_word", rd_data, {W'(7*512), W'(6*512), W'(5*512),
                W'(4*512), W'(3*512), W'(2*512), W'(512), W'(0)});
        end
        drain(2);
        rd_done = 1; step(); idle();
        chk("t1_buf_cnt_empty", DW'(buf_cnt), DW'(0));

        // 2: fill both buffers completely with random data
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < DEPTH; a++) begin
                rand_wr('1);
                for (int i = 0; i < NB; i++) wr_addr[i*AW +: AW] = AW'(a);
                step();
            end
            idle(); wr_done = 1; step(); idle();
        end
        chk("t2_buf_cnt", DW'(buf_cnt), DW'(2));
        chk("t2_wr_ready", DW'(wr_ready), DW'(0));
        rand_wr(NB'(8'h5a)); step(); idle();
        chk("t2_err_wr", DW'(err), DW'(2'b01));
        for (int k = 0; k < 64; k++) begin rand_rd(); step(); end
        drain(2);

        // 3: streaming overlap
        rd_done = 1; step(); idle();
        for (int k = 0; k < 40; k++) begin
            rand_wr(NB'($urandom)); rand_rd(); step();
        end
        idle(); wr_done = 1; rd_done = 1; step(); idle();
        chk("t3a_buf_cnt", DW'(buf_cnt), DW'(1));
        for (int k = 0; k < 40; k++) begin
            rand_wr(NB'($urandom)); rand_rd(); step();
        end
        idle(); wr_done = 1; rd_done = 1; step(); idle();
        chk("t3b_buf_cnt", DW'(buf_cnt), DW'(1));
        chk("t3b_rd_ready", DW'(rd_ready), DW'(1));
        chk("t3b_wr_ready", DW'(wr_ready), DW'(1));

        // 4: read in the same cycle as releasing the buffer
        rand_rd(); rd_done = 1; step(); idle();
        chk("t4_rd_ready", DW'(rd_ready), DW'(0));
        step();
        chk("t4_rd_valid", DW'(rd_valid), DW'(1));
        drain(2);

        // 5: read side misuse with both buffers empty
        rst = 1; step(); idle();
        rand_rd(); rd_done = 1; step(); idle();
        chk("t5_err", DW'(err), DW'(2'b10));
        chk("t5_buf_cnt", DW'(buf_cnt), DW'(0));
        step();
        chk("t5_rd_valid", DW'(rd_valid), DW'(0));
        chk("t5_rd_data", rd_data, DW'(0));
        drain(2);

        // 6: reset one cycle after an accepted read
        rst = 1; step(); idle();
        for (int k = 0; k < 8; k++) begin rand_wr('1); step(); end
        idle(); wr_done = 1; step(); idle();
        rand_rd(); step(); idle();
        rst = 1; step(); idle();
        chk("t6_wr_ready", DW'(wr_ready), DW'(1));
        chk("t6_rd_ready", DW'(rd_ready), DW'(0));
        chk("t6_buf_cnt", DW'(buf_cnt), DW'(0));
        chk("t6_err", DW'(err), DW'(0));
        chk("t6_rd_valid", DW'(rd_valid), DW'(0));
        drain(3);

        // Random traffic
        for (int k = 0; k < 1500; k++) begin
            idle();
            if ($urandom_range(0, 299) == 0) rst = 1;
            else begin
                rand_wr(($urandom_range(0, 3) == 0) ? NB'(0) : NB'($urandom));
                if ($urandom_range(0, 1) == 1) rand_rd();
                wr_done = ($urandom_range(0, 24) == 0);
                rd_done = ($urandom_range(0, 24) == 0);
            end
            step();
        end
        drain(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
